powerup_ctrl: RTL

//  Game-side controller for one power pack. Paces the pack lifecycle:

---
 rtl/powerup_ctrl_if.sv | 25 ++
 rtl/powerup_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/powerup_ctrl_if.sv
// Pack-side bus between the game controller and one power pack.
// The controller issues spawn/eaten with spawn coordinates; the pack answers
// with its latched position, picked mode and the coordinate-latch ack.
interface powerup_ctrl_if;
    logic        spawn;
    logic        eaten;
    logic [10:0] randx;
    logic [9:0]  randy;
    logic [10:0] pack_x;
    logic [9:0]  pack_y;
    logic [1:0]  pack_mode;
    logic        randop;

    // Controller side
    modport master (
        output spawn, eaten, randx, randy,
        input  pack_x, pack_y, pack_mode, randop
    );

    // Pack side
    modport slave (
        input  spawn, eaten, randx, randy,
        output pack_x, pack_y, pack_mode, randop
    );
endinterface

// File: rtl/powerup_ctrl.sv
// Power pack lifecycle controller: cooldown -> spawn -> armed -> effect.
// Generates spawn coordinates from a free-running Galois LFSR, detects the
// puck picking up the pack, and decodes the picked mode into effect enables.
module powerup_ctrl #(
    parameter int          WIDTH           = 20,
    parameter int          HEIGHT          = 20,
    parameter int          PUCK_SIZE       = 16,
    parameter int          COOLDOWN_FRAMES = 300,
    parameter int          EFFECT_FRAMES   = 600,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic [10:0]          puck_x,
    input  logic [9:0]           puck_y,
    input  logic                 puck_dir,
    powerup_ctrl_if.master       pack,
    output logic                 shrink_active,
    output logic                 boost_active,
    output logic                 shield_active,
    output logic                 effect_owner
);

    localparam int MAX_FRAMES = (COOLDOWN_FRAMES > EFFECT_FRAMES) ? COOLDOWN_FRAMES : EFFECT_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

    localparam logic [1:0] MODE_SHRINK = 2'b00;
    localparam logic [1:0] MODE_BOOST  = 2'b01;
    localparam logic [1:0] MODE_RSVD   = 2'b10;
    localparam logic [1:0] MODE_SHIELD = 2'b11;

    typedef enum logic [1:0] {
        COOLDOWN = 2'd0,
        SPAWN    = 2'd1,
        ARMED    = 2'd2,
        EFFECT   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [10:0]       randx_q, randx_d;
    logic [9:0]        randy_q, randy_d;
    logic              hit_q, hit_d;
    logic              eaten_q, eaten_d;
    logic [1:0]        mode_q, mode_d;
    logic              owner_q, owner_d;

    logic [10:0]       randx_free;
    logic [9:0]        randy_free;
    logic              overlap;

    // LFSR next value and the unheld coordinate candidates derived from it
    always_comb begin
        lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        randx_free = 11'd64 + 11'(lfsr_q[8:0]) + 11'(lfsr_q[15:8]);
        randy_free = 10'd64 + 10'(lfsr_q[8:0]);
        // Coordinates stay frozen while the pack is being asked to spawn
        if (state_q == SPAWN) begin
            randx_d = randx_q;
            randy_d = randy_q;
        end else begin
            randx_d = randx_free;
            randy_d = randy_free;
        end
    end

    // Strict box overlap, widened by one bit so right/bottom edges cannot wrap
    always_comb begin
        logic [11:0] px, kx;
        logic [10:0] py, ky;
        px = {1'b0, puck_x};
        kx = {1'b0, pack.pack_x};
        py = {1'b0, puck_y};
        ky = {1'b0, pack.pack_y};
        overlap = (px < kx + 12'(WIDTH))  && (kx < px + 12'(PUCK_SIZE)) &&
                  (py < ky + 11'(HEIGHT)) && (ky < py + 11'(PUCK_SIZE));
    end

    // Lifecycle next-state, frame counting and pickup latching
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        mode_d      = mode_q;
        owner_d     = owner_q;
        eaten_d     = 1'b0;
        // Only an armed pack can be hit; parked or hidden packs are ignored
        hit_d       = (state_q == ARMED) && overlap;

        unique case (state_q)
            COOLDOWN: begin
                if (frame_tick) begin
                    if (frame_cnt_q >= CNT_W'(COOLDOWN_FRAMES - 1)) begin
                        frame_cnt_d = '0;
                        state_d     = SPAWN;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            SPAWN: begin
                frame_cnt_d = '0;
                if (pack.randop) state_d = ARMED;
            end
            ARMED: begin
                frame_cnt_d = '0;
                if (hit_q) begin
                    eaten_d     = 1'b1;
                    state_d     = EFFECT;
                    mode_d      = pack.pack_mode;
                    owner_d     = puck_dir;
                    // A tick landing on the pickup cycle belongs to the effect
                    frame_cnt_d = frame_tick ? CNT_W'(1) : '0;
                end
            end
            EFFECT: begin
                if (mode_q == MODE_RSVD) begin
                    // Reserved mode has no effect; cooldown counts this tick
                    state_d     = COOLDOWN;
                    frame_cnt_d = frame_tick ? CNT_W'(1) : '0;
                end else if (frame_tick) begin
                    if (frame_cnt_q >= CNT_W'(EFFECT_FRAMES - 1)) begin
                        frame_cnt_d = '0;
                        state_d     = COOLDOWN;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d     = COOLDOWN;
                frame_cnt_d = '0;
            end
        endcase
    end

    // State and datapath registers; reset overrides everything
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= COOLDOWN;
            frame_cnt_q <= '0;
            lfsr_q      <= LFSR_SEED;
            randx_q     <= randx_free;
            randy_q     <= randy_free;
            hit_q       <= 1'b0;
            eaten_q     <= 1'b0;
            mode_q      <= 2'b00;
            owner_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            lfsr_q      <= lfsr_d;
            randx_q     <= randx_d;
            randy_q     <= randy_d;
            hit_q       <= hit_d;
            eaten_q     <= eaten_d;
            mode_q      <= mode_d;
            owner_q     <= owner_d;
        end
    end

    // Output decode: enables are one-hot by construction of the mode compare
    always_comb begin
        pack.spawn    = (state_q == SPAWN);
        pack.eaten    = eaten_q;
        pack.randx    = randx_q;
        pack.randy    = randy_q;
        shrink_active = (state_q == EFFECT) && (mode_q == MODE_SHRINK);
        boost_active  = (state_q == EFFECT) && (mode_q == MODE_BOOST);
        shield_active = (state_q == EFFECT) && (mode_q == MODE_SHIELD);
        effect_owner  = (state_q == EFFECT) && (mode_q != MODE_RSVD) && owner_q;
    end

endmodule
